int_seq: RTL and testbench
==========================

Name: int_seq

Overview:
- Interrupt/BRK entry sequencer for the 6502-compatible core. It is the reader side of the processor status register: it samples P, pushes it to the stack, and drives the status register's SEI strobe.
- It arbitrates NMI, BRK and IRQ at instruction boundaries. It then runs the fixed push/vector-fetch sequence over the memory bus and hands the new PC to the PC register.

Parameters:
- NMI_VEC, 16'hFFFA, address of the NMI vector low byte
- IRQ_VEC, 16'hFFFE, address of the IRQ/BRK vector low byte
- STACK_PAGE, 8'h01, high byte of every stack address

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- NMI_n  in  1  NMI request, active-low, falling-edge sensitive, synchronous to Clk
- IRQ_n  in  1  IRQ request, active-low, level sensitive
- BRK  in  1  BRK opcode decoded, from control unit
- Instr_Boundary  in  1  high for one cycle when the CPU may accept an interrupt
- P_In  in  8  current status register value
- PC_In  in  16  return PC to push (control supplies PC+2 for BRK)
- SP_In  in  8  current stack pointer
- Mem_Data_In  in  8  memory read data, valid the cycle after Mem_RE
- Busy  out  1  sequence in progress; CPU fetch stalled
- Mem_Addr  out  16  memory address
- Mem_Data_Out  out  8  memory write data
- Mem_WE  out  1  memory write strobe
- Mem_RE  out  1  memory read strobe
- SP_Dec  out  1  one-cycle stack pointer decrement pulse
- SEI  out  1  one-cycle set-I strobe to the status register
- PC_Out  out  16  new PC (vector)
- PC_Load  out  1  one-cycle PC load strobe
- Done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State goes to IDLE; all outputs are 0, Mem_Addr=0, PC_Out=0.
  - nmi_pending clears; NMI sample flop sets to 1.
  - Reset mid-sequence abandons the sequence at once, with no further writes or strobes.
- NMI edge detect:
  - nmi_q <= NMI_n every cycle.
  - nmi_pending sets when nmi_q=1 && NMI_n=0, in any state.
  - nmi_pending clears only on NMI acceptance. If set and clear occur in the same cycle, the set wins.
- Acceptance happens only in IDLE with Instr_Boundary=1. Priority is NMI (nmi_pending) > BRK > IRQ (IRQ_n=0 && P_In[2]=0).
- On acceptance, capture in one cycle:
  - PC_In, SP_In
  - p_push = {P_In[7:6], 1'b1, brk_sel, P_In[3:0]}
  - vector = NMI_VEC if NMI, else IRQ_VEC
- Next cycle, enter PUSH_PCH. Busy=1 in every non-IDLE state.
- States and Moore outputs (sp is the captured SP; all sp arithmetic is 8-bit wrap):
  - PUSH_PCH: Mem_Addr={STACK_PAGE,sp}, Mem_Data_Out=PC[15:8], Mem_WE=1, SP_Dec=1
  - PUSH_PCL: Mem_Addr={STACK_PAGE,sp-1}, Mem_Data_Out=PC[7:0], Mem_WE=1, SP_Dec=1
  - PUSH_P: Mem_Addr={STACK_PAGE,sp-2}, Mem_Data_Out=p_push, Mem_WE=1, SP_Dec=1, SEI=1
  - VEC_LO: Mem_Addr=vector, Mem_RE=1
  - VEC_HI: Mem_Addr=vector+1, Mem_RE=1; capture Mem_Data_In as vec_lo
  - LOAD_PC: PC_Out={Mem_Data_In, vec_lo}, PC_Load=1, Done=1; next state IDLE
- Total busy time is 6 cycles. Accept cycle to PC_Load is 6 cycles.
- Requests during a sequence:
  - A new NMI edge stays pending and is served at the next boundary after IDLE. There is no vector hijack.
  - IRQ/BRK changes during a sequence are ignored.
- Because SEI fires in PUSH_P, an IRQ cannot be re-accepted back-to-back. An NMI can be.
- Pushed P always has bit5=1. Bit4=1 only for BRK.

Test Plan:
1. IRQ_n=0, P_In=8'h00, PC_In=16'hC123, SP_In=8'hFD, vector bytes FFFE=34, FFFF=12 -> writes 0x01FD=C1, 0x01FC=23, 0x01FB=20; SEI and three SP_Dec pulses; PC_Out=16'h1234 with PC_Load 6 cycles after accept.
2. BRK=1, IRQ_n=0 same cycle, P_In=8'h81 -> pushed P=8'hB1; vector fetched from FFFE.
3. IRQ_n=0 with P_In[2]=1 at boundary -> no acceptance, Busy stays 0. NMI falling edge simultaneous with IRQ -> NMI wins, vector FFFA/FFFB, pushed P bit4=0.
4. SP_In=8'h01 -> push addresses 0x0101, 0x0100, 0x01FF (wrap).
5. NMI edge during VEC_LO of an IRQ sequence -> IRQ completes normally; NMI accepted at the next Instr_Boundary.
6. Reset asserted during PUSH_PCL -> Mem_WE and Busy drop immediately, no PC_Load occurs, and an earlier pending NMI is cleared.

Source files
------------

// File: rtl/int_seq.sv
// Interrupt/BRK entry sequencer: arbitrates NMI > BRK > IRQ at instruction boundaries,
// pushes PCH/PCL/P to the stack, fetches the vector and loads the new PC six cycles after accept.
module int_seq #(
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        NMI_n,
  input  logic        IRQ_n,
  input  logic        BRK,
  input  logic        Instr_Boundary,
  input  logic [7:0]  P_In,
  input  logic [15:0] PC_In,
  input  logic [7:0]  SP_In,
  input  logic [7:0]  Mem_Data_In,
  output logic        Busy,
  output logic [15:0] Mem_Addr,
  output logic [7:0]  Mem_Data_Out,
  output logic        Mem_WE,
  output logic        Mem_RE,
  output logic        SP_Dec,
  output logic        SEI,
  output logic [15:0] PC_Out,
  output logic        PC_Load,
  output logic        Done
);

  typedef enum logic [2:0] {
    IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_HI, LOAD_PC
  } state_t;

  state_t      state;
  logic        nmi_q;
  logic        nmi_pending;
  logic [15:0] pc;
  logic [15:0] vector;
  logic [7:0]  sp;
  logic [7:0]  p_push;
  logic [7:0]  vec_lo;
  logic        irq_req;
  logic        accept;
  logic        brk_sel;

  assign irq_req = !IRQ_n && !P_In[2];
  assign accept  = (state == IDLE) && Instr_Boundary && (nmi_pending || BRK || irq_req);
  assign brk_sel = !nmi_pending && BRK;

  // The high vector byte arrives on the bus during LOAD_PC itself, so PC_Out cannot be registered.
  assign PC_Out = (state == LOAD_PC) ? {Mem_Data_In, vec_lo} : 16'h0000;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      nmi_q       <= 1'b1;
      nmi_pending <= 1'b0;
    end else begin
      nmi_q <= NMI_n;
      if (nmi_q && !NMI_n)
        nmi_pending <= 1'b1;
      else if (accept && nmi_pending)
        nmi_pending <= 1'b0;
    end
  end

  // Outputs are loaded together with the state they belong to, so they are Moore and glitch-free.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      Busy         <= 1'b0;
      Mem_Addr     <= 16'h0000;
      Mem_Data_Out <= 8'h00;
      Mem_WE       <= 1'b0;
      Mem_RE       <= 1'b0;
      SP_Dec       <= 1'b0;
      SEI          <= 1'b0;
      PC_Load      <= 1'b0;
      Done         <= 1'b0;
      pc           <= 16'h0000;
      vector       <= 16'h0000;
      sp           <= 8'h00;
      p_push       <= 8'h00;
      vec_lo       <= 8'h00;
    end else begin
      Busy         <= 1'b0;
      Mem_Addr     <= 16'h0000;
      Mem_Data_Out <= 8'h00;
      Mem_WE       <= 1'b0;
      Mem_RE       <= 1'b0;
      SP_Dec       <= 1'b0;
      SEI          <= 1'b0;
      PC_Load      <= 1'b0;
      Done         <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pc           <= PC_In;
            sp           <= SP_In;
            p_push       <= (P_In & 8'hCF) | {2'b00, 1'b1, brk_sel, 4'b0000};
            vector       <= nmi_pending ? NMI_VEC : IRQ_VEC;
            state        <= PUSH_PCH;
            Busy         <= 1'b1;
            Mem_Addr     <= {STACK_PAGE, SP_In};
            Mem_Data_Out <= PC_In[15:8];
            Mem_WE       <= 1'b1;
            SP_Dec       <= 1'b1;
          end
        end
        PUSH_PCH: begin
          state        <= PUSH_PCL;
          Busy         <= 1'b1;
          Mem_Addr     <= {STACK_PAGE, sp - 8'd1};
          Mem_Data_Out <= pc[7:0];
          Mem_WE       <= 1'b1;
          SP_Dec       <= 1'b1;
        end
        PUSH_PCL: begin
          state        <= PUSH_P;
          Busy         <= 1'b1;
          Mem_Addr     <= {STACK_PAGE, sp - 8'd2};
          Mem_Data_Out <= p_push;
          Mem_WE       <= 1'b1;
          SP_Dec       <= 1'b1;
          SEI          <= 1'b1;
        end
        PUSH_P: begin
          state    <= VEC_LO;
          Busy     <= 1'b1;
          Mem_Addr <= vector;
          Mem_RE   <= 1'b1;
        end
        VEC_LO: begin
          state    <= VEC_HI;
          Busy     <= 1'b1;
          Mem_Addr <= vector + 16'd1;
          Mem_RE   <= 1'b1;
        end
        VEC_HI: begin
          vec_lo  <= Mem_Data_In;
          state   <= LOAD_PC;
          Busy    <= 1'b1;
          PC_Load <= 1'b1;
          Done    <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: vector table of full entry sequences plus mid-sequence NMI and reset cases.
module tb_int_seq;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        NMI_n = 1'b1;
  logic        IRQ_n = 1'b1;
  logic        BRK = 1'b0;
  logic        Instr_Boundary = 1'b0;
  logic [7:0]  P_In = 8'h00;
  logic [15:0] PC_In = 16'h0000;
  logic [7:0]  SP_In = 8'h00;
  logic [7:0]  Mem_Data_In = 8'h00;
  logic        Busy, Mem_WE, Mem_RE, SP_Dec, SEI, PC_Load, Done;
  logic [15:0] Mem_Addr, PC_Out;
  logic [7:0]  Mem_Data_Out;

  int_seq dut (
    .Clk(Clk), .Reset(Reset), .NMI_n(NMI_n), .IRQ_n(IRQ_n), .BRK(BRK),
    .Instr_Boundary(Instr_Boundary), .P_In(P_In), .PC_In(PC_In), .SP_In(SP_In),
    .Mem_Data_In(Mem_Data_In), .Busy(Busy), .Mem_Addr(Mem_Addr),
    .Mem_Data_Out(Mem_Data_Out), .Mem_WE(Mem_WE), .Mem_RE(Mem_RE), .SP_Dec(SP_Dec),
    .SEI(SEI), .PC_Out(PC_Out), .PC_Load(PC_Load), .Done(Done)
  );

  always #5 Clk = ~Clk;

  logic [7:0] mem [0:65535];
  always @(posedge Clk) begin
    if (Mem_RE) Mem_Data_In <= mem[Mem_Addr];
    if (Mem_WE) mem[Mem_Addr] <= Mem_Data_Out;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  int          busy_cnt, we_cnt, re_cnt, sei_cnt, spd_cnt, load_k, done_cnt;
  logic [15:0] wa [0:2];
  logic [7:0]  wd [0:2];
  logic [15:0] ra [0:1];
  logic [15:0] pc_got;

  // Drive request inputs, optionally pulse NMI one cycle ahead, then hold a boundary for one edge.
  task automatic start(input logic irq_n, input logic brk, input logic nmi,
                       input logic [7:0] p, input logic [15:0] pc, input logic [7:0] sp);
    @(negedge Clk);
    IRQ_n = irq_n; BRK = brk; P_In = p; PC_In = pc; SP_In = sp;
    if (nmi) NMI_n = 1'b0;
    @(negedge Clk);
    Instr_Boundary = 1'b1;
    @(negedge Clk);
    Instr_Boundary = 1'b0; BRK = 1'b0; IRQ_n = 1'b1; NMI_n = 1'b1;
  endtask

  // Sample ten post-accept cycles; nmi_at>0 drops NMI_n for one cycle at that cycle index.
  task automatic observe(input int nmi_at);
    busy_cnt = 0; we_cnt = 0; re_cnt = 0; sei_cnt = 0; spd_cnt = 0; load_k = 0;
    done_cnt = 0; pc_got = 16'h0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge Clk);
      NMI_n = (k == nmi_at) ? 1'b0 : 1'b1;
      if (Busy) busy_cnt++;
      if (SEI) sei_cnt++;
      if (SP_Dec) spd_cnt++;
      if (Done) done_cnt++;
      if (Mem_WE) begin
        if (we_cnt < 3) begin wa[we_cnt] = Mem_Addr; wd[we_cnt] = Mem_Data_Out; end
        we_cnt++;
      end
      if (Mem_RE) begin
        if (re_cnt < 2) ra[re_cnt] = Mem_Addr;
        re_cnt++;
      end
      if (PC_Load) begin load_k = k; pc_got = PC_Out; end
    end
    NMI_n = 1'b1;
  endtask

  task automatic check_seq(input string tag, input logic [15:0] a0, input logic [7:0] d0,
                           input logic [15:0] a1, input logic [7:0] d1,
                           input logic [15:0] a2, input logic [7:0] d2,
                           input logic [15:0] vec, input logic [15:0] newpc);
    chk({tag, " busy_cycles"}, busy_cnt, 6);
    chk({tag, " write_count"}, we_cnt, 3);
    chk({tag, " pch_addr"}, wa[0], a0);
    chk({tag, " pch_data"}, wd[0], d0);
    chk({tag, " pcl_addr"}, wa[1], a1);
    chk({tag, " pcl_data"}, wd[1], d1);
    chk({tag, " p_addr"}, wa[2], a2);
    chk({tag, " p_data"}, wd[2], d2);
    chk({tag, " sei_pulses"}, sei_cnt, 1);
    chk({tag, " spdec_pulses"}, spd_cnt, 3);
    chk({tag, " read_count"}, re_cnt, 2);
    chk({tag, " vec_lo_addr"}, ra[0], vec);
    chk({tag, " vec_hi_addr"}, ra[1], vec + 16'd1);
    chk({tag, " pc_load_cycle"}, load_k, 6);
    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " pc_out"}, pc_got, newpc);
  endtask

  typedef struct {
    string       name;
    logic        irq_n, brk, nmi;
    logic [7:0]  p;
    logic [15:0] pc;
    logic [7:0]  sp;
    logic        acc;
    logic [15:0] a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    logic [15:0] vec, newpc;
  } vec_t;

  vec_t tbl [0:5];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFA] = 8'hCD; mem[16'hFFFB] = 8'hAB;
    mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h12;

    tbl[0] = '{"irq", 1'b0, 1'b0, 1'b0, 8'h00, 16'hC123, 8'hFD, 1'b1,
               16'h01FD, 16'h01FC, 16'h01FB, 8'hC1, 8'h23, 8'h20, 16'hFFFE, 16'h1234};
    tbl[1] = '{"brk_irq", 1'b0, 1'b1, 1'b0, 8'h81, 16'h8002, 8'hF0, 1'b1,
               16'h01F0, 16'h01EF, 16'h01EE, 8'h80, 8'h02, 8'hB1, 16'hFFFE, 16'h1234};
    tbl[2] = '{"irq_masked", 1'b0, 1'b0, 1'b0, 8'h04, 16'h1111, 8'hFF, 1'b0,
               16'h0, 16'h0, 16'h0, 8'h0, 8'h0, 8'h0, 16'h0, 16'h0};
    tbl[3] = '{"nmi_irq", 1'b0, 1'b0, 1'b1, 8'h00, 16'h4567, 8'h80, 1'b1,
               16'h0180, 16'h017F, 16'h017E, 8'h45, 8'h67, 8'h20, 16'hFFFA, 16'hABCD};
    tbl[4] = '{"sp_wrap", 1'b0, 1'b0, 1'b0, 8'hC3, 16'h0102, 8'h01, 1'b1,
               16'h0101, 16'h0100, 16'h01FF, 8'h01, 8'h02, 8'hE3, 16'hFFFE, 16'h1234};
    tbl[5] = '{"nmi_iset", 1'b1, 1'b0, 1'b1, 8'h34, 16'hFFEE, 8'h00, 1'b1,
               16'h0100, 16'h01FF, 16'h01FE, 8'hFF, 8'hEE, 8'h24, 16'hFFFA, 16'hABCD};

    #12;
    chk("reset busy", Busy, 0);
    chk("reset we", Mem_WE, 0);
    chk("reset addr", Mem_Addr, 16'h0);
    chk("reset pc_out", PC_Out, 16'h0);
    chk("reset strobes", {Mem_RE, SP_Dec, SEI, PC_Load, Done}, 5'b0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start(tbl[i].irq_n, tbl[i].brk, tbl[i].nmi, tbl[i].p, tbl[i].pc, tbl[i].sp);
      observe(0);
      if (tbl[i].acc)
        check_seq(tbl[i].name, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1,
                  tbl[i].a2, tbl[i].d2, tbl[i].vec, tbl[i].newpc);
      else begin
        chk({tbl[i].name, " busy_cycles"}, busy_cnt, 0);
        chk({tbl[i].name, " pc_load_cycle"}, load_k, 0);
      end
    end

    // NMI edge during VEC_LO of an IRQ: IRQ keeps its vector, NMI follows at the next boundary.
    start(1'b0, 1'b0, 1'b0, 8'h00, 16'h2000, 8'hFD);
    observe(4);
    check_seq("irq_then", 16'h01FD, 8'h20, 16'h01FC, 8'h00, 16'h01FB, 8'h20, 16'hFFFE, 16'h1234);
    start(1'b1, 1'b0, 1'b0, 8'h00, 16'h3000, 8'hFA);
    observe(0);
    check_seq("nmi_after", 16'h01FA, 8'h30, 16'h01F9, 8'h00, 16'h01F8, 8'h20, 16'hFFFA, 16'hABCD);

    // Reset in PUSH_PCL with an NMI pending from PUSH_PCH.
    start(1'b0, 1'b0, 1'b0, 8'h00, 16'h5000, 8'hFD);
    NMI_n = 1'b0;
    @(negedge Clk);
    NMI_n = 1'b1;
    chk("pre_reset we", Mem_WE, 1);
    Reset = 1'b1;
    #1;
    chk("reset_mid we", Mem_WE, 0);
    chk("reset_mid busy", Busy, 0);
    @(negedge Clk);
    Reset = 1'b0;
    Instr_Boundary = 1'b1;
    busy_cnt = 0; load_k = 0; we_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (Busy) busy_cnt++;
      if (Mem_WE) we_cnt++;
      if (PC_Load) load_k = k;
    end
    Instr_Boundary = 1'b0;
    chk("post_reset busy", busy_cnt, 0);
    chk("post_reset writes", we_cnt, 0);
    chk("post_reset pc_load", load_k, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
